regfile_2w2r_sb: RTL

- Parametrised successor to the 8x8 register file: WIDTH-bit by DEPTH-entry array with two combinational read ports and two synchronous write ports.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard: the issue stage marks a register pending, and writeback clears it.
- Sits between the decode/issue stage (reads, issue marks) and the ALU/load writeback paths (wr0 = ALU, wr1 = load).

---
 rtl/regfile_2w2r_sb.sv | 107 ++++++++++
 1 files changed

// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with an optional write-to-read bypass,
// an optional hardwired-zero register 0 and a per-register busy scoreboard.
module regfile_2w2r_sb #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [WIDTH-1:0]  rs1_data,
   output logic [WIDTH-1:0]  rs2_data,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [WIDTH-1:0]  wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [WIDTH-1:0]  wr1_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic [ADDR_W:0]   busy_cnt,
   output logic              any_busy
);

   localparam int CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0]  regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;
   logic [DEPTH-1:0]  wr0_hit;
   logic [DEPTH-1:0]  wr1_hit;
   logic [DEPTH-1:0]  issue_hit;
   logic [CNT_W-1:0]  cnt_next;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_data [2];

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      wr0_hit   = '0;
      wr1_hit   = '0;
      issue_hit = '0;
      cnt_next  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr0_hit[i]   = wr0_en   && (wr0_addr   == ADDR_W'(i));
         wr1_hit[i]   = wr1_en   && (wr1_addr   == ADDR_W'(i));
         issue_hit[i] = issue_en && (issue_addr == ADDR_W'(i));
      end
      if (ZERO_REG != 0) begin
         wr0_hit[0]   = 1'b0;
         wr1_hit[0]   = 1'b0;
         issue_hit[0] = 1'b0;
      end
      // A fresh issue outranks a same-cycle writeback: the new producer is still outstanding.
      busy_next = issue_hit | (busy & ~(wr0_hit | wr1_hit));
      for (int i = 0; i < DEPTH; i++) begin
         cnt_next = cnt_next + CNT_W'(busy_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array must clear on reset, so it is built from resettable flops, not a RAM macro.
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
         for (int i = 0; i < DEPTH; i++) begin
            if (wr1_hit[i]) begin
               regs[i] <= wr1_data;
            end else if (wr0_hit[i]) begin
               regs[i] <= wr0_data;
            end
         end
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

   assign rd_addr[0] = rs1_addr;
   assign rd_addr[1] = rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs[rd_addr[p]];
         if (BYPASS != 0) begin
            if (wr0_en && (wr0_addr == rd_addr[p])) rd_data[p] = wr0_data;
            if (wr1_en && (wr1_addr == rd_addr[p])) rd_data[p] = wr1_data;
         end
         if ((ZERO_REG != 0) && (rd_addr[p] == '0)) rd_data[p] = '0;
      end
   end

   assign rs1_data = rd_data[0];
   assign rs2_data = rd_data[1];
   assign rs1_busy = busy[rs1_addr];
   assign rs2_busy = busy[rs2_addr];
   assign any_busy = (busy_cnt != '0);

endmodule
